// File: rtl/ieee_adder_pipe.sv
// Three-stage IEEE-754 add/subtract (flush-to-zero, RNE) with valid/ready handshake.
// Result appears 3 edges after acceptance; a stalled output freezes every stage and drops in_ready.
module ieee_adder_pipe #(
  parameter int EXPO_LEN        = 8,
  parameter int SIGNIFICAND_LEN = 23,
  parameter int GUARDBITS       = 3,
  localparam int TOTALBITS      = 1 + EXPO_LEN + SIGNIFICAND_LEN
) (
  input  logic                 clock_in,
  input  logic                 reset_n_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 add_sub_bit,
  input  logic [TOTALBITS-1:0] inputA,
  input  logic [TOTALBITS-1:0] inputB,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TOTALBITS-1:0] outputC,
  output logic                 flag_overflow,
  output logic                 flag_underflow,
  output logic                 flag_inexact,
  output logic                 flag_invalid
);

  localparam int M  = SIGNIFICAND_LEN;
  localparam int G  = GUARDBITS;
  localparam int SW = 1 + M + G;
  localparam int EW = EXPO_LEN + 2;
  localparam logic [EXPO_LEN-1:0]  EXP_ONES = '1;
  localparam logic [EW-1:0]        EXP_MAX  = {2'b00, EXP_ONES};
  localparam logic [SW-1:0]        SW_ONES  = '1;
  localparam logic [TOTALBITS-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};

  logic stall, adv;
  logic s1_vld_q, s2_vld_q, s3_vld_q;

  assign stall    = s3_vld_q && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  // ---------------- stage 1: unpack, classify, swap, align ----------------
  logic                sa, sb, a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic [EXPO_LEN-1:0] ea, eb, ex, ey, shamt;
  logic [M-1:0]        fa, fb, fx, fy;
  logic                sx, sy, zx, zy, sticky;
  logic [SW-1:0]       x_sig, y_sig, y_sh, y_al;
  logic [TOTALBITS-1:0] spec_val_d;

  always_comb begin
    sa = inputA[TOTALBITS-1];
    sb = inputB[TOTALBITS-1] ^ add_sub_bit;
    ea = inputA[TOTALBITS-2 -: EXPO_LEN];
    eb = inputB[TOTALBITS-2 -: EXPO_LEN];
    fa = inputA[M-1:0];
    fb = inputB[M-1:0];
    a_max  = (ea == EXP_ONES);
    b_max  = (eb == EXP_ONES);
    a_nan  = a_max && (fa != '0);
    b_nan  = b_max && (fb != '0);
    a_inf  = a_max && (fa == '0);
    b_inf  = b_max && (fb == '0);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    // Subnormals count as zero magnitude for the swap decision too
    swap = (b_zero ? {(EXPO_LEN+M){1'b0}} : {eb, fb}) > (a_zero ? {(EXPO_LEN+M){1'b0}} : {ea, fa});

    sx = sa; ex = ea; fx = fa; zx = a_zero;
    sy = sb; ey = eb; fy = fb; zy = b_zero;
    if (swap) begin
      sx = sb; ex = eb; fx = fb; zx = b_zero;
      sy = sa; ey = ea; fy = fa; zy = a_zero;
    end

    x_sig  = zx ? '0 : {1'b1, fx, {G{1'b0}}};
    y_sig  = zy ? '0 : {1'b1, fy, {G{1'b0}}};
    shamt  = ex - ey;
    y_sh   = '0;
    sticky = 1'b0;
    if (32'(shamt) >= SW) begin
      y_al = {{(SW-1){1'b0}}, |y_sig};
    end else begin
      y_sh   = y_sig >> shamt;
      sticky = |(y_sig & ~(SW_ONES << shamt));
      y_al   = {y_sh[SW-1:1], y_sh[0] | sticky};
    end

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) spec_val_d = QNAN;
    else if (a_inf)                                        spec_val_d = {sa, EXP_ONES, {M{1'b0}}};
    else                                                   spec_val_d = {sb, EXP_ONES, {M{1'b0}}};
  end

  logic                 s1_sign_q, s1_sub_q, s1_zsign_q, s1_spec_q, s1_inv_q;
  logic [EXPO_LEN-1:0]  s1_exp_q;
  logic [SW-1:0]        s1_x_q, s1_y_q;
  logic [TOTALBITS-1:0] s1_spec_val_q;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      s1_vld_q      <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_zsign_q    <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_inv_q      <= 1'b0;
      s1_exp_q      <= '0;
      s1_x_q        <= '0;
      s1_y_q        <= '0;
      s1_spec_val_q <= '0;
    end else if (adv) begin
      s1_vld_q      <= in_valid;
      s1_sign_q     <= sx;
      s1_sub_q      <= sx ^ sy;
      s1_zsign_q    <= sa & sb;
      s1_spec_q     <= a_max | b_max;
      s1_inv_q      <= a_nan | b_nan | (a_inf & b_inf & (sa != sb));
      s1_exp_q      <= ex;
      s1_x_q        <= x_sig;
      s1_y_q        <= y_al;
      s1_spec_val_q <= spec_val_d;
    end
  end

  // ---------------- stage 2: add/subtract and normalise ----------------
  logic [SW:0]   sum;
  logic [SW-1:0] body_s, s2_sig_d;
  logic [EW-1:0] exp_base, lzc, s2_exp_d;
  logic          s2_sign_d, s2_zero_d, s2_uf_d;

  always_comb begin
    sum      = s1_sub_q ? ({1'b0, s1_x_q} - {1'b0, s1_y_q}) : ({1'b0, s1_x_q} + {1'b0, s1_y_q});
    body_s   = sum[SW-1:0];
    exp_base = {2'b00, s1_exp_q};
    lzc      = EW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (body_s[i]) lzc = EW'(SW - 1 - i);
    end

    s2_sig_d  = body_s << lzc;
    s2_exp_d  = exp_base - lzc;
    s2_sign_d = s1_sign_q;
    s2_zero_d = 1'b0;
    s2_uf_d   = 1'b0;
    if (sum[SW]) begin
      s2_sig_d = {sum[SW:2], sum[1] | sum[0]};
      s2_exp_d = exp_base + EW'(1);
    end else if (body_s == '0) begin
      s2_zero_d = 1'b1;
      s2_sign_d = s1_zsign_q;
      s2_sig_d  = '0;
      s2_exp_d  = '0;
    end else if (lzc >= exp_base) begin
      s2_uf_d = 1'b1;
    end
  end

  logic                 s2_sign_q, s2_zero_q, s2_uf_q, s2_spec_q, s2_inv_q;
  logic [EW-1:0]        s2_exp_q;
  logic [SW-1:0]        s2_sig_q;
  logic [TOTALBITS-1:0] s2_spec_val_q;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      s2_vld_q      <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_zero_q     <= 1'b0;
      s2_uf_q       <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_inv_q      <= 1'b0;
      s2_exp_q      <= '0;
      s2_sig_q      <= '0;
      s2_spec_val_q <= '0;
    end else if (adv) begin
      s2_vld_q      <= s1_vld_q;
      s2_sign_q     <= s2_sign_d;
      s2_zero_q     <= s2_zero_d;
      s2_uf_q       <= s2_uf_d;
      s2_spec_q     <= s1_spec_q;
      s2_inv_q      <= s1_inv_q;
      s2_exp_q      <= s2_exp_d;
      s2_sig_q      <= s2_sig_d;
      s2_spec_val_q <= s1_spec_val_q;
    end
  end

  // ---------------- stage 3: round to nearest even, pack ----------------
  logic                 g_bit, rs_bits, rnd_up;
  logic [M+1:0]         mant;
  logic [EW-1:0]        exp_r;
  logic [M-1:0]         frac;
  logic [TOTALBITS-1:0] c_d;
  logic                 ovf_d, unf_d, inx_d, inv_d;

  always_comb begin
    g_bit   = s2_sig_q[G-1];
    rs_bits = |s2_sig_q[G-2:0];
    rnd_up  = g_bit & (rs_bits | s2_sig_q[G]);
    mant    = {1'b0, s2_sig_q[SW-1:G]} + (M+2)'(rnd_up);
    exp_r   = s2_exp_q + EW'(mant[M+1]);
    frac    = mant[M+1] ? mant[M:1] : mant[M-1:0];

    c_d   = {s2_sign_q, exp_r[EXPO_LEN-1:0], frac};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = g_bit | rs_bits;
    inv_d = 1'b0;
    if (s2_spec_q) begin
      c_d   = s2_spec_val_q;
      inx_d = 1'b0;
      inv_d = s2_inv_q;
    end else if (s2_zero_q) begin
      c_d   = {s2_sign_q, {(TOTALBITS-1){1'b0}}};
      inx_d = 1'b0;
    end else if (s2_uf_q) begin
      c_d   = {s2_sign_q, {(TOTALBITS-1){1'b0}}};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else if (exp_r >= EXP_MAX) begin
      c_d   = {s2_sign_q, EXP_ONES, {M{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end
  end

  logic [TOTALBITS-1:0] c_q;
  logic                 ovf_q, unf_q, inx_q, inv_q;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      s3_vld_q <= 1'b0;
      c_q      <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else if (adv) begin
      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        c_q   <= c_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        inx_q <= inx_d;
        inv_q <= inv_d;
      end
    end
  end

  assign out_valid      = s3_vld_q;
  assign outputC        = c_q;
  assign flag_overflow  = ovf_q;
  assign flag_underflow = unf_q;
  assign flag_inexact   = inx_q;
  assign flag_invalid   = inv_q;

endmodule

// File: tb/tb_ieee_adder_pipe.sv
// Directed-vector bench for ieee_adder_pipe (binary32 configuration).
module tb_ieee_adder_pipe;

  logic        clock_in = 1'b0;
  logic        reset_n_in, in_valid, in_ready, add_sub_bit, out_valid, out_ready;
  logic [31:0] inputA, inputB, outputC;
  logic        flag_overflow, flag_underflow, flag_inexact, flag_invalid;
  logic [3:0]  flags;

  assign flags = {flag_overflow, flag_underflow, flag_inexact, flag_invalid};

  ieee_adder_pipe dut (
    .clock_in      (clock_in),
    .reset_n_in    (reset_n_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .add_sub_bit   (add_sub_bit),
    .inputA        (inputA),
    .inputB        (inputB),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .outputC       (outputC),
    .flag_overflow (flag_overflow),
    .flag_underflow(flag_underflow),
    .flag_inexact  (flag_inexact),
    .flag_invalid  (flag_invalid)
  );

  always #5 clock_in = ~clock_in;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] c;
    logic [3:0]  f;   // {overflow, underflow, inexact, invalid}
  } vec_t;

  vec_t vecs[12] = '{
    '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000},  // 1+1
    '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000},  // 3-1
    '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000},  // 1-1 -> +0
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0010},  // tie, even stays
    '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0010},  // tie, odd rounds up
    '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0010},  // above half
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1010},  // overflow
    '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0001},  // inf-inf
    '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0001},  // NaN in
    '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000},  // 1-inf
    '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0110},  // underflow flush
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000}   // -0 + -0
  };

  logic [31:0] bp_b[5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
  logic [31:0] bp_c[5] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};

  // Called at posedge+1; checks nothing emerges after 2 edges and the result after 3.
  task automatic run_op(input vec_t v, input string tag);
    inputA      = v.a;
    inputB      = v.b;
    add_sub_bit = v.sub;
    in_valid    = 1'b1;
    @(posedge clock_in); #1;
    in_valid = 1'b0;
    @(posedge clock_in); #1;
    check({tag, ".early_vld"}, 32'(out_valid), 32'd0);
    @(posedge clock_in); #1;
    check({tag, ".vld"}, 32'(out_valid), 32'd1);
    check({tag, ".c"}, outputC, v.c);
    check({tag, ".flags"}, 32'(flags), 32'(v.f));
  endtask

  initial begin
    int          sent, rcvd;
    logic        was_stall;
    logic [31:0] held;

    reset_n_in  = 1'b0;
    in_valid    = 1'b0;
    add_sub_bit = 1'b0;
    inputA      = '0;
    inputB      = '0;
    out_ready   = 1'b1;
    #2;
    check("rst.vld", 32'(out_valid), 32'd0);
    check("rst.c", outputC, 32'd0);
    check("rst.flags", 32'(flags), 32'd0);
    #10 reset_n_in = 1'b1;
    @(posedge clock_in); #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_op(vecs[i], $sformatf("v%0d", i));
    @(posedge clock_in); #1;
    check("drain.vld", 32'(out_valid), 32'd0);

    // Back-pressure: stream 5 pairs, consumer stalls on cycles 4..8.
    sent = 0; rcvd = 0; was_stall = 1'b0; held = '0;
    add_sub_bit = 1'b0;
    inputA = 32'h3F800000;
    for (int c = 1; c <= 20; c++) begin
      out_ready = !(c >= 4 && c <= 8);
      in_valid  = (sent < 5);
      inputB    = bp_b[(sent < 5) ? sent : 0];
      #1;
      if (out_valid && !out_ready) begin
        check($sformatf("bp.in_ready.c%0d", c), 32'(in_ready), 32'd0);
        if (was_stall) check($sformatf("bp.hold.c%0d", c), outputC, held);
        held = outputC;
        was_stall = 1'b1;
      end else begin
        was_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (rcvd < 5) check($sformatf("bp.res%0d", rcvd), outputC, bp_c[rcvd]);
        else          check("bp.extra", 32'(rcvd), 32'd4);
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clock_in); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp.sent", 32'(sent), 32'd5);
    check("bp.rcvd", 32'(rcvd), 32'd5);

    // Reset while results are in flight.
    inputA   = 32'h3F800000;
    inputB   = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clock_in); #1;
    inputB = 32'h40000000;
    @(posedge clock_in); #1;
    in_valid = 1'b0;
    @(posedge clock_in); #3;
    check("mid.pre_vld", 32'(out_valid), 32'd1);
    reset_n_in = 1'b0;
    #1;
    check("mid.vld", 32'(out_valid), 32'd0);
    check("mid.c", outputC, 32'd0);
    @(posedge clock_in);
    @(posedge clock_in); #2;
    reset_n_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock_in); #1;
      check($sformatf("mid.stale%0d", k), 32'(out_valid), 32'd0);
    end
    run_op(vecs[1], "post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ieee_adder_pipe.md
Name: ieee_adder_pipe

Overview:
- Parametrised, fully pipelined IEEE-754 adder/subtractor computing C = A ± B.
- Generalised in exponent and significand width.
- Adds behaviour the single-stage adder lacks:
  - normalisation after effective subtraction
  - round-to-nearest-even
  - special values
  - exception flags
  - valid/ready flow control with back-pressure
- Sits between operand-issue logic and the result writeback/FIFO of the float datapath.

Parameters:
- EXPO_LEN, 8, exponent field width (bias = 2^(EXPO_LEN-1)-1).
- SIGNIFICAND_LEN, 23, stored fraction width (hidden bit excluded).
- GUARDBITS, 3, guard/round/sticky bits appended below the LSB; minimum 3.
- TOTALBITS, 1+EXPO_LEN+SIGNIFICAND_LEN, derived word width; not overridable.

Ports:
- clock_in  in  1  rising-edge clock.
- reset_n_in  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts an operand pair this cycle.
- add_sub_bit  in  1  0 = A+B, 1 = A−B.
- inputA  in  TOTALBITS  operand A.
- inputB  in  TOTALBITS  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- outputC  out  TOTALBITS  result.
- flag_overflow  out  1  result rounded to ±infinity from finite operands.
- flag_underflow  out  1  nonzero result flushed to zero.
- flag_inexact  out  1  rounding discarded nonzero bits.
- flag_invalid  out  1  inf − inf or NaN operand.

Behaviour:
- Reset, asynchronous:
  - All stage valid bits clear; out_valid=0.
  - outputC=0 and all flags=0.
  - in_ready=1 once reset is released.
  - Operations in flight when reset asserts are discarded; no partial result ever appears.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Stall = out_valid && !out_ready. During a stall all three stages hold and in_ready=0, so no bubble-collapse is required.
  - outputC and flags are stable while out_valid && !out_ready.
  - Results leave in acceptance order.
- Latency and throughput:
  - A result is presented 3 rising edges after acceptance.
  - Throughput is 1 result per cycle with out_ready held high.
- Stage 1, unpack/align:
  - Effective sign of B = B.sign ^ add_sub_bit.
  - Exponent 0 (subnormal/zero) is treated as signed zero on input (flush-to-zero).
  - Operands are swapped so the larger magnitude, compared as {exponent, fraction}, is X. The result sign is X's sign.
  - Y's significand {1, frac, GUARDBITS zeros} is right-shifted by expX−expY.
  - The lowest bit is sticky: the OR of all shifted-out bits.
  - Shift amounts ≥ SIGNIFICAND_LEN+GUARDBITS+1 produce Y=0 with sticky = (Y nonzero).
- Stage 2, add/normalise:
  - Effective add gives a 1-bit-wider sum. On carry, shift right 1 (sticky preserved) and exp+1.
  - Effective subtract gives X−Y ≥ 0.
  - A leading-zero count over the full significand drives the left shift by lzc; exp −= lzc.
  - If exp would drop to ≤0, the result is flushed to zero and flag_underflow is set.
  - An exact zero result gives +0, except (−0)+(−0) gives −0.
- Stage 3, round/pack:
  - Round-to-nearest, ties-to-even, using guard/round/sticky.
  - Rounding carry-out renormalises the result (exp+1).
  - exp reaching 2^EXPO_LEN−1 yields ±inf with flag_overflow=1 and flag_inexact=1.
  - flag_inexact = (G|R|S) != 0, or overflow, or flush of a nonzero value.
- Special values, decided in stage 1 and carried as a bypass through the pipeline:
  - Any NaN operand gives a quiet NaN {0, all-ones exp, 1 followed by zeros} with flag_invalid=1.
  - inf ± inf with opposite effective signs gives the same quiet NaN with flag_invalid=1.
  - Otherwise, any inf operand passes through with its effective sign; no flags.
- Flags are per-result and are not sticky across operations.

Test Plan:
- Basic add: 0x3F800000 + 0x3F800000, add_sub_bit=0, out_ready=1 → after 3 edges outputC=0x40000000, out_valid=1, all flags 0.
- Subtract with normalisation:
  - 0x40400000 − 0x3F800000 → 0x40000000.
  - 0x3F800000 − 0x3F800000 → 0x00000000 (+0), no flags.
- Rounding:
  - 0x3F800000 + 0x33800000 (exact tie) → 0x3F800000, flag_inexact=1.
  - 0x3F800001 + 0x33800000 → 0x3F800002, flag_inexact=1.
- Exceptions:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flag_overflow=1, flag_inexact=1.
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, flag_invalid=1.
  - 0x7FC00000 + 0x3F800000 → 0x7FC00000, flag_invalid=1.
- Back-pressure: stream 5 back-to-back pairs with out_ready=0 for cycles 4–8 → in_ready=0 during the stall; outputC held stable; all 5 results later emerge in order with none lost or duplicated.
- Reset mid-flight: accept 2 ops, drop reset_n_in asynchronously between edges → out_valid=0 and outputC=0 immediately; after release no stale result appears and the next op returns after exactly 3 edges.
